// File: rtl/fpu_accumulator.sv
// Packet accumulator around an external combinational floating-point adder.
// Beats are summed until in_last, then the result is held until out_ready.
module fpu_accumulator #(
  parameter int unsigned double = 0,
  localparam int unsigned W = (double != 0) ? 64 : 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W-1:0] add_result,
  input  logic         add_exception,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic [15:0]  out_count,
  output logic         out_exception
);

  localparam int unsigned EW = (double != 0) ? 11 : 8;

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e       state;
  logic [W-1:0] acc;
  logic [15:0]  count;
  logic         sticky;

  function automatic logic exp_ones(input logic [W-1:0] v);
    return &v[W-2 -: EW];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      acc       <= '0;
      count     <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          // The first beat is loaded verbatim; the adder is not involved.
          if (in_valid) begin
            acc       <= in_data;
            count     <= 16'd1;
            sticky    <= exp_ones(in_data);
            state     <= in_last ? StHold : StAcc;
            out_valid <= in_last;
          end
        end
        StAcc: begin
          if (in_valid) begin
            acc       <= add_result;
            count     <= (count == 16'hffff) ? count : count + 16'd1;
            sticky    <= sticky | add_exception | exp_ones(add_result);
            state     <= in_last ? StHold : StAcc;
            out_valid <= in_last;
          end
        end
        StHold: begin
          if (out_ready) begin
            state     <= StIdle;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= StIdle;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = ~rst & (state != StHold);
  assign add_a         = acc;
  assign add_b         = in_data;
  assign out_sum       = out_valid ? acc : '0;
  assign out_count     = out_valid ? count : 16'd0;
  assign out_exception = out_valid & sticky;

endmodule
